// File: rtl/pulse_stretcher.sv
// Per-channel pulse-to-level stretcher: a trigger pulse holds level_o high for
// length_i cycles, then done_o strobes once in the first low cycle.
module pulse_stretcher #(
  parameter int WIDTH     = 1,
  parameter int CNT_W     = 8,
  parameter bit RETRIGGER = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] pulse_i,
  input  logic [CNT_W-1:0] length_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] done_o
);

  logic [WIDTH-1:0]            level_q, level_d;
  logic [WIDTH-1:0]            done_q, done_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                        len_nz;

  assign len_nz = (length_i != '0);

  always_comb begin
    level_d = level_q;
    done_d  = '0;
    cnt_d   = cnt_q;
    for (int c = 0; c < WIDTH; c++) begin
      if (!level_q[c]) begin
        if (pulse_i[c] && len_nz) begin
          level_d[c] = 1'b1;
          cnt_d[c]   = length_i - CNT_W'(1);
        end
      end else if (RETRIGGER && pulse_i[c] && len_nz) begin
        // cnt holds the remaining high cycles after the current one
        cnt_d[c] = length_i - CNT_W'(1);
      end else if (cnt_q[c] != '0) begin
        cnt_d[c] = cnt_q[c] - CNT_W'(1);
      end else begin
        level_d[c] = 1'b0;
        done_d[c]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level_q <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: a retriggerable 4-channel instance and a
// non-retriggerable 1-channel instance checked against an end-cycle model.
module tb_pulse_stretcher;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] pulse_a = '0;
  logic [2:0] len_a = '0;
  logic [3:0] level_a, done_a;
  logic [0:0] pulse_b = '0;
  logic [7:0] len_b = '0;
  logic [0:0] level_b, done_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pulse_stretcher #(.WIDTH(4), .CNT_W(3), .RETRIGGER(1'b1)) dut_a (
    .clk(clk), .resetn(resetn), .pulse_i(pulse_a), .length_i(len_a),
    .level_o(level_a), .done_o(done_a)
  );

  pulse_stretcher #(.WIDTH(1), .CNT_W(8), .RETRIGGER(1'b0)) dut_b (
    .clk(clk), .resetn(resetn), .pulse_i(pulse_b), .length_i(len_b),
    .level_o(level_b), .done_o(done_b)
  );

  // Model: each channel remembers the last cycle its level is high.
  // Level is high while cyc <= end; done is the single cycle end+1.
  int cyc = 0;
  int end_a [4] = '{-100, -100, -100, -100};
  int end_b = -100;

  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) end_a[i] = -100;
      end_b = -100;
    end else begin
      for (int i = 0; i < 4; i++)
        if (pulse_a[i] && len_a != 0) end_a[i] = cyc + int'(len_a);
      if (pulse_b[0] && len_b != 0 && !(cyc <= end_b)) end_b = cyc + int'(len_b);
    end
    cyc++;
  end

  function automatic logic [3:0] exp_lvl_a();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = resetn && (cyc <= end_a[i]);
    return r;
  endfunction

  function automatic logic [3:0] exp_done_a();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = resetn && (cyc == end_a[i] + 1);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_level_a", 32'(level_a), 32'(exp_lvl_a()));
    chk("model_done_a",  32'(done_a),  32'(exp_done_a()));
    chk("model_level_b", 32'(level_b), 32'(resetn && (cyc <= end_b)));
    chk("model_done_b",  32'(done_b),  32'(resetn && (cyc == end_b + 1)));
  end

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // reset held with toggling triggers
    len_a = 3'd5; len_b = 8'd5;
    for (int k = 0; k < 4; k++) begin
      pulse_a = k[0] ? 4'hF : 4'h0;
      pulse_b = k[0];
      tick();
    end
    chk("rst_level_a", 32'(level_a), 32'h0);
    chk("rst_done_a",  32'(done_a),  32'h0);
    chk("rst_level_b", 32'(level_b), 32'h0);
    pulse_a = '0; pulse_b = '0;
    resetn = 1'b1;
    tick(2);

    // basic length 5 on both instances
    pulse_a = 4'b0001; len_a = 3'd5; pulse_b = 1'b1; len_b = 8'd5;
    tick(); pulse_a = '0; pulse_b = '0;
    chk("basic_t1_level", 32'(level_a), 32'h1);
    tick(4);
    chk("basic_t5_level", 32'(level_a), 32'h1);
    chk("basic_t5_done",  32'(done_a),  32'h0);
    tick();
    chk("basic_t6_level", 32'(level_a), 32'h0);
    chk("basic_t6_done",  32'(done_a),  32'h1);
    chk("basic_t6_done_b", 32'(done_b), 32'h1);
    tick();
    chk("basic_t7_done",  32'(done_a),  32'h0);
    tick(2);

    // pulses at t and t+2, length 4
    pulse_a = 4'b0001; len_a = 3'd4; pulse_b = 1'b1; len_b = 8'd4;
    tick(); pulse_a = '0; pulse_b = '0;
    tick(); pulse_a = 4'b0001; pulse_b = 1'b1;
    tick(); pulse_a = '0; pulse_b = '0;
    tick();
    chk("noretrig_t4_level", 32'(level_b), 32'h1);
    tick();
    chk("noretrig_t5_done",  32'(done_b),  32'h1);
    chk("retrig_t5_level",   32'(level_a), 32'h1);
    tick();
    chk("retrig_t6_level",   32'(level_a), 32'h1);
    chk("retrig_t6_done",    32'(done_a),  32'h0);
    tick();
    chk("retrig_t7_level",   32'(level_a), 32'h0);
    chk("retrig_t7_done",    32'(done_a),  32'h1);
    tick(2);

    // retrigger in the final active cycle
    pulse_a = 4'b0001; len_a = 3'd4;
    tick(); pulse_a = '0;
    tick(3);
    chk("final_t4_level", 32'(level_a), 32'h1);
    pulse_a = 4'b0001; len_a = 3'd3;
    tick(); pulse_a = '0;
    chk("final_t5_level", 32'(level_a), 32'h1);
    chk("final_t5_done",  32'(done_a),  32'h0);
    tick(2);
    chk("final_t7_level", 32'(level_a), 32'h1);
    tick();
    chk("final_t8_done",  32'(done_a),  32'h1);
    tick(2);

    // non-retrigger with pulse held high: 4 high, 1 low, repeating
    pulse_b = 1'b1; len_b = 8'd4;
    tick(5);
    chk("hold_t5_level", 32'(level_b), 32'h0);
    chk("hold_t5_done",  32'(done_b),  32'h1);
    tick();
    chk("hold_t6_level", 32'(level_b), 32'h1);
    tick(4);
    chk("hold_t10_done", 32'(done_b),  32'h1);
    tick(2);
    pulse_b = '0;
    tick(6);

    // zero length at idle, then during an active level
    pulse_a = 4'b0001; len_a = 3'd0; pulse_b = 1'b1; len_b = 8'd0;
    tick(); pulse_a = '0; pulse_b = '0;
    chk("zero_idle_level", 32'(level_a), 32'h0);
    chk("zero_idle_level_b", 32'(level_b), 32'h0);
    tick();
    chk("zero_idle_done", 32'(done_a), 32'h0);
    pulse_a = 4'b0001; len_a = 3'd5;
    tick(); pulse_a = '0;
    tick(); pulse_a = 4'b0001; len_a = 3'd0;
    tick(); pulse_a = '0;
    tick(2);
    chk("zero_act_t5_level", 32'(level_a), 32'h1);
    tick();
    chk("zero_act_t6_done", 32'(done_a), 32'h1);
    tick(2);

    // multi-channel with different start times and lengths
    pulse_a = 4'b0101; len_a = 3'd7;
    tick(); pulse_a = '0;
    tick(2); pulse_a = 4'b0010; len_a = 3'd2;
    tick(); pulse_a = '0;
    chk("multi_t4_level", 32'(level_a), 32'h7);
    tick();
    chk("multi_t5_level", 32'(level_a), 32'h7);
    tick();
    chk("multi_t6_level", 32'(level_a), 32'h5);
    chk("multi_t6_done",  32'(done_a),  32'h2);
    tick();
    chk("multi_t7_level", 32'(level_a), 32'h5);
    chk("multi_t7_done",  32'(done_a),  32'h0);
    tick();
    chk("multi_t8_level", 32'(level_a), 32'h0);
    chk("multi_t8_done",  32'(done_a),  32'h5);
    tick(2);

    // asynchronous reset mid-level, no done after release
    pulse_a = 4'b1111; len_a = 3'd7; pulse_b = 1'b1; len_b = 8'd7;
    tick(); pulse_a = '0; pulse_b = '0;
    tick(2);
    #3 resetn = 1'b0;
    #1;
    chk("async_rst_level_a", 32'(level_a), 32'h0);
    chk("async_rst_level_b", 32'(level_b), 32'h0);
    tick(2);
    resetn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("post_rst_done_a", 32'(done_a), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Converts single-cycle pulses back into levels; the inverse of the level-to-pulse edge detection used on control strobes.
- Each of WIDTH independent channels holds level_o high for a programmable number of cycles after a trigger pulse.
- A one-cycle done_o strobe marks the end of each level.
- Sits between pulse-generating control logic and consumers that need a held enable or busy level.

Parameters:
- WIDTH, 1, number of independent channels.
- CNT_W, 8, width of length_i and of each per-channel down-counter. Maximum level length is 2^CNT_W-1 cycles.
- RETRIGGER, 1, 1 = a pulse while active reloads the counter (extends the level); 0 = pulses while active are ignored.

Ports:
- clk, input, 1, rising-edge clock for all state.
- resetn, input, 1, asynchronous active-low reset. Assertion clears all state immediately; deassertion is sampled by clk.
- pulse_i, input, WIDTH, per-channel trigger, sampled each rising clk edge.
- length_i, input, CNT_W, level length in cycles, shared by all channels. Sampled only in the cycle a trigger is accepted.
- level_o, output, WIDTH, per-channel stretched level, registered.
- done_o, output, WIDTH, per-channel one-cycle end-of-level strobe, registered.

Behaviour:
- Per-channel state: level_o bit, done_o bit, CNT_W-bit counter cnt. Channels share no state except length_i.
- Reset (resetn=0, asynchronous): level_o=0, done_o=0, cnt=0 on all channels, including mid-level. No done_o is generated for a level cut short by reset.
- done_o default: 0 every cycle unless set by the end-of-level rule below.
- Idle channel (level_o=0):
  - pulse_i=1 and length_i!=0: next cycle level_o=1, cnt=length_i-1.
  - pulse_i=1 and length_i==0: ignored, no state change, no done_o.
- Active channel (level_o=1), no accepted trigger:
  - cnt!=0: cnt decrements by 1.
  - cnt==0: next cycle level_o=0, done_o=1 for exactly one cycle.
- Active channel, RETRIGGER=1, pulse_i=1, length_i!=0:
  - Next cycle cnt=length_i-1, level_o stays 1, no done_o.
  - Applies in any active cycle, including the final one (cnt==0).
  - Net effect: level stays high for length_i cycles after the trigger cycle.
- Active channel, RETRIGGER=1, pulse_i=1, length_i==0: treated as no trigger.
- Active channel, RETRIGGER=0: pulse_i ignored in every active cycle, including the final one.
- Latency: level_o rises 1 cycle after the trigger cycle and stays high exactly length_i cycles without retrigger. done_o asserts in the first cycle level_o is low again.
- Back-to-back: a pulse in the done_o cycle (level_o=0) is accepted as a new trigger. Minimum low gap between levels is 1 cycle.
  - RETRIGGER=0 with pulse_i held high: level_o is high length_i cycles, low 1 cycle, and repeats.
- Simultaneous triggers on several channels all start with the same length_i value.
- Counter never wraps. Decrement occurs only when cnt!=0.

Test Plan:
- Reset: hold resetn=0 with pulse_i toggling -> level_o=0, done_o=0. Assert resetn=0 asynchronously mid-level (between clock edges) -> level_o drops before the next edge; no done_o after release.
- Basic, WIDTH=1, length_i=5: pulse_i=1 at cycle t only -> level_o=1 on cycles t+1..t+5, done_o=1 on cycle t+6 only, level_o=0 from t+6.
- Retrigger, RETRIGGER=1, length_i=4: pulses at t and t+2 -> level_o=1 on t+1..t+6 (continuous), single done_o on t+7. Pulse at final cycle t+4 with length_i=3 (single trigger at t) -> level_o high through t+7, done_o on t+8.
- No-retrigger, RETRIGGER=0, length_i=4: pulses at t and t+2 -> level_o=1 on t+1..t+4, done_o on t+5. pulse_i held high from t -> pattern of 4 high, 1 low, repeating, with done_o on each low cycle.
- Zero length: length_i=0 with pulse_i=1 at idle -> no level_o and no done_o. With RETRIGGER=1 during an active level -> original end time unchanged.
- Multi-channel, WIDTH=4, CNT_W=3: pulse_i=4'b0101 at t (length_i=7), pulse_i=4'b0010 at t+3 (length_i=2) -> ch0 and ch2 high on t+1..t+7 with done_o on t+8; ch1 high on t+4..t+5 with done_o on t+6; ch3 stays 0 throughout.
